// File: rtl/uart_16550_tx_fifo.sv
// 16550-style transmit FIFO with first-word-fall-through head, registered flags and THRE pulse.
// Optional sticky overflow flag enabled by defining UART_TX_FIFO_OVERFLOW_EN.
module uart_16550_tx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  WBs_CLK_i,
  input  logic                  WBs_RST_n_i,
  input  logic                  Tx_FIFO_Enable_i,
  input  logic                  Tx_FIFO_Flush_i,
  input  logic                  Tx_FIFO_Push_i,
  input  logic [7:0]            Tx_FIFO_DAT_i,
  input  logic                  Tx_FIFO_Pop_i,
  output logic [7:0]            Tx_FIFO_DAT_o,
  output logic [DEPTH_LOG2:0]   Tx_FIFO_Level_o,
  output logic                  Tx_FIFO_Empty_o,
  output logic                  Tx_FIFO_Full_o,
  output logic                  Tx_THRE_Pulse_o,
  output logic                  Tx_FIFO_Overflow_o
);

  localparam int unsigned DEPTH = 2**DEPTH_LOG2;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   level, level_nxt, cap;
  logic                  empty_q, full_q, thre_q, enable_q;
  logic                  flush, push_ok, pop_ok, empty_nxt;

  always_comb begin
    cap       = enable_q ? (DEPTH_LOG2+1)'(DEPTH) : (DEPTH_LOG2+1)'(1);
    // A mode change discards contents exactly like an explicit flush.
    flush     = Tx_FIFO_Flush_i | (Tx_FIFO_Enable_i != enable_q);
    pop_ok    = Tx_FIFO_Pop_i & ~empty_q;
    // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
    push_ok   = Tx_FIFO_Push_i & (~full_q | pop_ok);
    level_nxt = level;
    if (flush)
      level_nxt = '0;
    else if (push_ok && !pop_ok)
      level_nxt = level + (DEPTH_LOG2+1)'(1);
    else if (pop_ok && !push_ok)
      level_nxt = level - (DEPTH_LOG2+1)'(1);
    empty_nxt = (level_nxt == '0);
  end

  always_ff @(posedge WBs_CLK_i) begin
    if (!WBs_RST_n_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      thre_q   <= 1'b0;
      enable_q <= 1'b0;
    end else begin
      enable_q <= Tx_FIFO_Enable_i;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      level   <= level_nxt;
      empty_q <= empty_nxt;
      full_q  <= (level_nxt == cap);
      thre_q  <= empty_nxt & ~empty_q;
    end
  end

  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_n_i && !flush && push_ok)
      mem[wr_ptr] <= Tx_FIFO_DAT_i;
  end

`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic ovf_q;

  always_ff @(posedge WBs_CLK_i) begin
    if (!WBs_RST_n_i)
      ovf_q <= 1'b0;
    else if (flush)
      ovf_q <= 1'b0;
    else if (Tx_FIFO_Push_i && full_q && !pop_ok)
      ovf_q <= 1'b1;
  end

  assign Tx_FIFO_Overflow_o = ovf_q;
`else
  assign Tx_FIFO_Overflow_o = 1'b0;
`endif

  assign Tx_FIFO_DAT_o   = empty_q ? '0 : mem[rd_ptr];
  assign Tx_FIFO_Level_o = level;
  assign Tx_FIFO_Empty_o = empty_q;
  assign Tx_FIFO_Full_o  = full_q;
  assign Tx_THRE_Pulse_o = thre_q;

endmodule

// File: tb/tb_uart_16550_tx_fifo.sv
// Scoreboard bench for uart_16550_tx_fifo: stimulus queues expected state, a monitor compares at negedge.
module tb_uart_16550_tx_fifo;

`ifdef UART_TX_FIFO_OVERFLOW_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       flush = 1'b0;
  logic       push = 1'b0;
  logic [7:0] din = '0;
  logic       pop = 1'b0;
  logic [7:0] dout;
  logic [4:0] level;
  logic       empty, full, thre, ovf;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  typedef struct {
    string      nm;
    int         lvl;
    logic       em;
    logic       fu;
    logic [7:0] dat;
    logic       th;
    logic       ov;
  } exp_t;

  exp_t exp_q[$];

  uart_16550_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .WBs_CLK_i          (clk),
    .WBs_RST_n_i        (rst_n),
    .Tx_FIFO_Enable_i   (enable),
    .Tx_FIFO_Flush_i    (flush),
    .Tx_FIFO_Push_i     (push),
    .Tx_FIFO_DAT_i      (din),
    .Tx_FIFO_Pop_i      (pop),
    .Tx_FIFO_DAT_o      (dout),
    .Tx_FIFO_Level_o    (level),
    .Tx_FIFO_Empty_o    (empty),
    .Tx_FIFO_Full_o     (full),
    .Tx_THRE_Pulse_o    (thre),
    .Tx_FIFO_Overflow_o (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req)
      $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, req);
    else
      n_pass++;
  endtask

  // Apply one cycle of stimulus, then queue the state expected after that edge.
  task automatic cyc(input string nm, input logic ps, input logic [7:0] d, input logic pp,
                     input logic fl, input int lvl, input logic em, input logic fu,
                     input logic [7:0] dat, input logic th, input logic ov);
    exp_t e;
    push  = ps;
    din   = d;
    pop   = pp;
    flush = fl;
    @(posedge clk);
    #1;
    push  = 1'b0;
    pop   = 1'b0;
    flush = 1'b0;
    e.nm = nm; e.lvl = lvl; e.em = em; e.fu = fu; e.dat = dat; e.th = th; e.ov = ov;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.nm, "level", 32'(level), 32'(e.lvl));
        chk(e.nm, "empty", 32'(empty), 32'(e.em));
        chk(e.nm, "full",  32'(full),  32'(e.fu));
        chk(e.nm, "dat",   32'(dout),  32'(e.dat));
        chk(e.nm, "thre",  32'(thre),  32'(e.th));
        chk(e.nm, "ovf",   32'(ovf),   32'(e.ov));
      end
    end
  end

  initial begin : stim
    // Reset
    cyc("rst0", 0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0);
    cyc("rst1", 0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0);
    rst_n = 1'b1;

    // Basic push/pop with FIFO mode; enable change acts as flush on an empty FIFO
    enable = 1'b1;
    cyc("en_on",  0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0);
    cyc("push11", 1, 8'h11, 0, 0, 1, 0, 0, 8'h11, 0, 0);
    cyc("push22", 1, 8'h22, 0, 0, 2, 0, 0, 8'h11, 0, 0);
    cyc("push33", 1, 8'h33, 0, 0, 3, 0, 0, 8'h11, 0, 0);
    cyc("pop1",   0, 8'h00, 1, 0, 2, 0, 0, 8'h22, 0, 0);
    cyc("pop2",   0, 8'h00, 1, 0, 1, 0, 0, 8'h33, 0, 0);
    cyc("pop3",   0, 8'h00, 1, 0, 0, 1, 0, 8'h00, 1, 0);
    cyc("idle1",  0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0);
    cyc("popemp", 0, 8'h00, 1, 0, 0, 1, 0, 8'h00, 0, 0);

    // Fill 16 (0x40..0x4F), then 17th push dropped
    for (int i = 1; i <= 16; i++)
      cyc($sformatf("fill%0d", i), 1, 8'(8'h3F + i), 0, 0, i, 0, (i == 16), 8'h40, 0, 0);
    cyc("push17", 1, 8'hEE, 0, 0, 16, 0, 1, 8'h40, 0, OVF);

    // Full: push+pop together keeps level, then drain across the pointer wrap
    cyc("fullpp", 1, 8'hAA, 1, 0, 16, 0, 1, 8'h41, 0, OVF);
    for (int k = 1; k <= 16; k++)
      cyc($sformatf("drain%0d", k), 0, 8'h00, 1, 0, 16 - k, (k == 16), 0,
          (k < 15) ? 8'(8'h41 + k) : ((k == 15) ? 8'hAA : 8'h00), (k == 16), OVF);
    cyc("flush_ovf", 0, 8'h00, 0, 1, 0, 1, 0, 8'h00, 0, 0);

    // Empty: push+pop together accepts only the push
    cyc("emptypp", 1, 8'h5A, 1, 0, 1, 0, 0, 8'h5A, 0, 0);
    for (int i = 1; i <= 4; i++)
      cyc($sformatf("lvl5_%0d", i), 1, 8'(i), 0, 0, 1 + i, 0, 0, 8'h5A, 0, 0);
    cyc("flushpush", 1, 8'h77, 0, 1, 0, 1, 0, 8'h00, 1, 0);
    cyc("idle2",     0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0);

    // Holding-register mode
    enable = 1'b0;
    cyc("en_off", 0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0);
    cyc("hold01", 1, 8'h01, 0, 0, 1, 0, 1, 8'h01, 0, 0);
    cyc("hold02", 1, 8'h02, 0, 0, 1, 0, 1, 8'h01, 0, OVF);
    enable = 1'b1;
    cyc("en_back", 0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 1, 0);
    cyc("push10", 1, 8'h10, 0, 0, 1, 0, 0, 8'h10, 0, 0);
    cyc("push20", 1, 8'h20, 0, 0, 2, 0, 0, 8'h10, 0, 0);

    // Reset mid-stream beats a concurrent push; no THRE on exit
    rst_n = 1'b0;
    cyc("midrst", 1, 8'h30, 0, 0, 0, 1, 0, 8'h00, 0, 0);
    rst_n = 1'b1;
    cyc("rstexit", 0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0);
    cyc("push99",  1, 8'h99, 0, 0, 1, 0, 0, 8'h99, 0, 0);

    repeat (2) @(negedge clk);
    chk("end", "pending", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_16550_tx_fifo.md
UART_16550_TX_FIFO -- requirements
Module: uart_16550_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, giving FIFO depth 2**DEPTH_LOG2 bytes (16).
REQ-002 SHALL have port WBs_CLK_i, input, 1 bit: single clock for all logic.
REQ-003 SHALL have port WBs_RST_n_i, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port Tx_FIFO_Enable_i, input, 1 bit: 1 selects FIFO mode, 0 selects single holding-register mode.
REQ-005 SHALL have port Tx_FIFO_Flush_i, input, 1 bit: clears contents and flags.
REQ-006 SHALL have port Tx_FIFO_Push_i, input, 1 bit: write strobe from the bus side.
REQ-007 SHALL have port Tx_FIFO_DAT_i, input, 8 bits: write data.
REQ-008 SHALL have port Tx_FIFO_Pop_i, input, 1 bit: read strobe from the transmitter shifter.
REQ-009 SHALL have port Tx_FIFO_DAT_o, output, 8 bits: head entry (first-word-fall-through).
REQ-010 SHALL have port Tx_FIFO_Level_o, output, DEPTH_LOG2+1 bits: current entry count.
REQ-011 SHALL have port Tx_FIFO_Empty_o, output, 1 bit: no entries (THRE).
REQ-012 SHALL have port Tx_FIFO_Full_o, output, 1 bit: capacity reached.
REQ-013 SHALL have port Tx_THRE_Pulse_o, output, 1 bit: one-cycle pulse on Empty 0->1.
REQ-014 SHALL have port Tx_FIFO_Overflow_o, output, 1 bit: sticky push-while-full flag.

Function
REQ-015 SHALL store entries in a circular buffer with DEPTH_LOG2-bit write/read pointers that wrap modulo depth.
REQ-016 SHALL set effective capacity to 2**DEPTH_LOG2 when Tx_FIFO_Enable_i=1 and to 1 when 0.
REQ-017 SHALL accept a push when not full: write DAT_i at write pointer, advance pointer, Level+1; effects visible the cycle after the edge.
REQ-018 SHALL accept a pop when not empty: advance read pointer, Level-1; DAT_o shows next entry the cycle after the edge.
REQ-019 SHALL ignore push when full (no storage, no pointer or level change) and pop when empty.
REQ-020 SHALL, on simultaneous push and pop with 0<Level<capacity, perform both; Level unchanged.
REQ-021 SHALL, on simultaneous push and pop when empty, accept only the push (Level 0->1).
REQ-022 SHALL, on simultaneous push and pop when full, perform both; Level stays at capacity, Full stays 1.
REQ-023 SHALL drive Tx_FIFO_DAT_o to 8'h00 whenever Tx_FIFO_Empty_o=1.
REQ-024 SHALL register Empty and Full: Empty=(Level==0), Full=(Level==capacity), both updated at the same edge as Level.
REQ-025 SHALL give Tx_FIFO_Flush_i priority over push and pop in the same cycle: pointers, Level=0, Empty=1, Full=0, Overflow=0 next cycle.
REQ-026 SHALL register Tx_FIFO_Enable_i and treat any cycle where input differs from the registered copy as a flush.
REQ-027 SHALL assert Tx_THRE_Pulse_o for exactly one cycle, the cycle Empty first reads 1 after reading 0, including when caused by flush.

Reset
REQ-028 SHALL, while WBs_RST_n_i=0 at a clock edge, clear pointers, Level=0, Empty=1, Full=0, THRE pulse=0, Overflow=0, registered enable=0.
REQ-029 SHALL give reset priority over flush, push and pop, and SHALL NOT produce a THRE pulse on reset exit.
REQ-030 SHALL NOT require storage array contents to be reset.

Configuration
REQ-031 SHALL, with UART_TX_FIFO_OVERFLOW_EN defined, set Tx_FIFO_Overflow_o on any push while full; it holds until reset or flush.
REQ-032 SHALL, without UART_TX_FIFO_OVERFLOW_EN, tie Tx_FIFO_Overflow_o to 0 and include no overflow register.

Verification
REQ-033 SHALL cover: reset, Enable=1, push 0x11,0x22,0x33 -> Level=3, Empty=0, DAT_o=0x11; 3 pops -> DAT_o 0x22,0x33,0x00, Empty=1, one THRE pulse.
REQ-034 SHALL cover: push 17 bytes with Enable=1 -> Full=1 after 16th; 17th dropped; Overflow=1 with macro, 0 without.
REQ-035 SHALL cover: full FIFO, push 0xAA+pop same cycle -> Level=16, Full=1; after 16 pops last DAT_o=0xAA (pointer wrap).
REQ-036 SHALL cover: empty FIFO, push 0x5A+pop same cycle -> Level=1, DAT_o=0x5A.
REQ-037 SHALL cover: Level=5, flush+push same cycle -> Level=0, Empty=1, Overflow=0, one THRE pulse.
REQ-038 SHALL cover: Enable=0, push 0x01 -> Full=1; push 0x02 ignored; Enable->1 -> Level=0, Empty=1; reset mid-stream -> all outputs at REQ-028 values.
